// File: rtl/vericlock.sv
// 24-hour HH:MM:SS clock with 1 Hz prescaler, edge-detected set buttons and
// combinational 7-segment decode of each two-digit field.
module vericlock #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic        inc_sec,
   input  logic        inc_min,
   input  logic        inc_hour,
   output logic [13:0] sec_7seg,
   output logic [13:0] min_7seg,
   output logic [13:0] hour_7seg
);

   localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [5:0]    sec_q, sec_d;
   logic [5:0]    min_q, min_d;
   logic [4:0]    hour_q, hour_d;
   logic          inc_sec_prev_q, inc_min_prev_q, inc_hour_prev_q;

   logic tick;
   logic sec_pulse, min_pulse, hour_pulse, any_pulse;
   logic sec_last, min_last, hour_last;

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   function automatic logic [13:0] field_7seg(input logic [5:0] value);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(value / 6'd10);
      ones = 4'(value % 6'd10);
      return {seg_encode(tens), seg_encode(ones)};
   endfunction

   assign tick = (presc_q == PRESC_LAST);

   assign sec_pulse  = inc_sec  & ~inc_sec_prev_q;
   assign min_pulse  = inc_min  & ~inc_min_prev_q;
   assign hour_pulse = inc_hour & ~inc_hour_prev_q;
   assign any_pulse  = sec_pulse | min_pulse | hour_pulse;

   assign sec_last  = (sec_q  == 6'd59);
   assign min_last  = (min_q  == 6'd59);
   assign hour_last = (hour_q == 5'd23);

   assign presc_d = tick ? '0 : presc_q + PW'(1);

   // A button press in the same cycle as a tick swallows that tick's second.
   always_comb begin
      sec_d  = sec_q;
      min_d  = min_q;
      hour_d = hour_q;
      if (any_pulse) begin
         if (sec_pulse)  sec_d  = sec_last  ? 6'd0 : sec_q  + 6'd1;
         if (min_pulse)  min_d  = min_last  ? 6'd0 : min_q  + 6'd1;
         if (hour_pulse) hour_d = hour_last ? 5'd0 : hour_q + 5'd1;
      end else if (tick) begin
         if (sec_last) begin
            sec_d = 6'd0;
            if (min_last) begin
               min_d  = 6'd0;
               hour_d = hour_last ? 5'd0 : hour_q + 5'd1;
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         presc_q         <= '0;
         sec_q           <= '0;
         min_q           <= '0;
         hour_q          <= '0;
         inc_sec_prev_q  <= 1'b0;
         inc_min_prev_q  <= 1'b0;
         inc_hour_prev_q <= 1'b0;
      end else begin
         presc_q         <= presc_d;
         sec_q           <= sec_d;
         min_q           <= min_d;
         hour_q          <= hour_d;
         inc_sec_prev_q  <= inc_sec;
         inc_min_prev_q  <= inc_min;
         inc_hour_prev_q <= inc_hour;
      end
   end

   assign sec_7seg  = field_7seg(sec_q);
   assign min_7seg  = field_7seg(min_q);
   assign hour_7seg = field_7seg({1'b0, hour_q});

endmodule

// File: tb/tb_vericlock.sv
// Directed bench for vericlock with TICK_DIV=10; presses are aligned to tick
// edges so each press swallows its tick and preloaded times stay exact.
module tb_vericlock;

   localparam int unsigned TICK_DIV = 10;

   localparam logic [13:0] D00 = 14'h1FBF;
   localparam logic [13:0] D01 = 14'h1F86;
   localparam logic [13:0] D05 = 14'h1FED;
   localparam logic [13:0] D06 = 14'h1FFD;
   localparam logic [13:0] D07 = 14'h1F87;
   localparam logic [13:0] D12 = 14'h035B;
   localparam logic [13:0] D23 = 14'h2DCF;
   localparam logic [13:0] D34 = 14'h27E6;
   localparam logic [13:0] D56 = 14'h36FD;
   localparam logic [13:0] D59 = 14'h36EF;

   logic        clk_100MHz = 1'b0;
   logic        reset      = 1'b1;
   logic        inc_sec    = 1'b0;
   logic        inc_min    = 1'b0;
   logic        inc_hour   = 1'b0;
   logic [13:0] sec_7seg;
   logic [13:0] min_7seg;
   logic [13:0] hour_7seg;

   int errors = 0;
   int checks = 0;

   vericlock #(.TICK_DIV(TICK_DIV)) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .inc_sec    (inc_sec),
      .inc_min    (inc_min),
      .inc_hour   (inc_hour),
      .sec_7seg   (sec_7seg),
      .min_7seg   (min_7seg),
      .hour_7seg  (hour_7seg)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk_100MHz);
      #1;
   endtask

   // Called right after a tick edge; the press lands on the next tick edge.
   task automatic press_on_tick(input logic s, input logic m, input logic h);
      edges(TICK_DIV - 1);
      inc_sec  = s;
      inc_min  = m;
      inc_hour = h;
      edges(1);
      inc_sec  = 1'b0;
      inc_min  = 1'b0;
      inc_hour = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      edges(n);
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state and first tick latency
      do_reset(10);
      check("rst_sec",  sec_7seg,  D00);
      check("rst_min",  min_7seg,  D00);
      check("rst_hour", hour_7seg, D00);
      edges(TICK_DIV - 1);
      check("pre_first_tick_sec", sec_7seg, D00);
      edges(1);
      check("first_tick_sec", sec_7seg, D01);

      // 60 ticks since reset -> 00:01:00
      edges(59 * TICK_DIV);
      check("t60_sec",  sec_7seg,  D00);
      check("t60_min",  min_7seg,  D01);
      check("t60_hour", hour_7seg, D00);

      // Preload 23:59:59 with simultaneous multi-field presses
      do_reset(2);
      for (int i = 1; i <= 59; i++)
         press_on_tick(1'b1, 1'b1, (i <= 23));
      check("pre_sec",  sec_7seg,  D59);
      check("pre_min",  min_7seg,  D59);
      check("pre_hour", hour_7seg, D23);

      // Full rollover
      edges(TICK_DIV);
      check("roll_sec",  sec_7seg,  D00);
      check("roll_min",  min_7seg,  D00);
      check("roll_hour", hour_7seg, D00);

      // Held button counts once
      inc_min = 1'b1;
      edges(50);
      inc_min = 1'b0;
      check("hold_min",  min_7seg,  D01);
      check("hold_sec",  sec_7seg,  D05);
      check("hold_hour", hour_7seg, D00);

      // Press coincident with tick drops the tick
      press_on_tick(1'b1, 1'b0, 1'b0);
      check("coinc_sec", sec_7seg, D06);
      edges(TICK_DIV);
      check("after_coinc_sec", sec_7seg, D07);

      // Preload 12:59:56
      do_reset(2);
      for (int i = 1; i <= 59; i++)
         press_on_tick((i <= 56), 1'b1, (i <= 12));
      check("p2_sec",  sec_7seg,  D56);
      check("p2_min",  min_7seg,  D59);
      check("p2_hour", hour_7seg, D12);

      // Minute wraps without carrying into hours
      press_on_tick(1'b0, 1'b1, 1'b0);
      check("mwrap_min",  min_7seg,  D00);
      check("mwrap_hour", hour_7seg, D12);
      check("mwrap_sec",  sec_7seg,  D56);

      for (int i = 0; i < 34; i++)
         press_on_tick(1'b0, 1'b1, 1'b0);
      edges(3);
      check("t123456_hour", hour_7seg, D12);
      check("t123456_min",  min_7seg,  D34);
      check("t123456_sec",  sec_7seg,  D56);

      // Reset mid-count restarts with a fresh prescaler phase
      do_reset(1);
      check("mid_rst_sec",  sec_7seg,  D00);
      check("mid_rst_min",  min_7seg,  D00);
      check("mid_rst_hour", hour_7seg, D00);
      edges(TICK_DIV - 1);
      check("mid_rst_pre_tick", sec_7seg, D00);
      edges(1);
      check("mid_rst_tick", sec_7seg, D01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
